// File: rtl/id_ex_pkg.sv
// Shared definitions for the ID->EX pipeline stage: control-word layout and the occupancy state type.
package id_ex_pkg;

  localparam int unsigned CTRL_W_DEF    = 16;

  localparam int unsigned CTRL_BRANCH   = 0;
  localparam int unsigned CTRL_MEMREAD  = 1;
  localparam int unsigned CTRL_MEMWRITE = 2;
  localparam int unsigned CTRL_REGWRITE = 3;
  localparam int unsigned CTRL_MEMTOREG = 4;
  localparam int unsigned CTRL_REGDST   = 5;
  localparam int unsigned CTRL_ALUOP_LO = 6;
  localparam int unsigned CTRL_ALUOP_HI = 8;
  localparam int unsigned CTRL_ALUSRC   = 9;
  localparam int unsigned CTRL_SWAP     = 10;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } slot_state_e;

endpackage

// File: rtl/id_ex_skid_stage_pipe_slot.sv
// Generic valid + payload register. Clear wins over load; clear leaves the payload untouched.
module pipe_slot #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/id_ex_skid_stage.sv
// ID->EX pipeline register with valid/ready handshake, flush, optional 2-entry skid buffer
// and a saturating stall counter. Output control is masked to zero whenever the stage is empty.
module id_ex_skid_stage
  import id_ex_pkg::*;
#(
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REGF_W = 5,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              InValid,
  output logic              InReady,
  input  logic [CTRL_W-1:0] InCtrl,
  input  logic [DATA_W-1:0] InPC,
  input  logic [DATA_W-1:0] InRD1,
  input  logic [DATA_W-1:0] InRD2,
  input  logic [DATA_W-1:0] InImm,
  input  logic [REGF_W-1:0] InRd,
  input  logic [REGF_W-1:0] InRt,
  input  logic              Flush,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [CTRL_W-1:0] OutCtrl,
  output logic [DATA_W-1:0] OutPC,
  output logic [DATA_W-1:0] OutRD1,
  output logic [DATA_W-1:0] OutRD2,
  output logic [DATA_W-1:0] OutImm,
  output logic [REGF_W-1:0] OutRd,
  output logic [REGF_W-1:0] OutRt,
  output logic [CNT_W-1:0]  StallCnt
);

  localparam int unsigned PAY_W = CTRL_W + 4 * DATA_W + 2 * REGF_W;

  slot_state_e       state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic [PAY_W-1:0]  in_pay, m_pay, s_pay, m_load_data;
  logic [CTRL_W-1:0] m_ctrl;
  logic              m_valid, s_valid;
  logic              m_load, m_clear, s_load, s_clear;
  logic              in_ready, accept, retire;

  assign in_pay   = {InCtrl, InPC, InRD1, InRD2, InImm, InRd, InRt};
  assign in_ready = (SKID != 0) ? in_ready_q : (!m_valid || OutReady);
  assign accept   = InValid && in_ready;
  assign retire   = m_valid && OutReady;

  always_comb begin
    state_d     = state_q;
    m_load      = 1'b0;
    m_clear     = 1'b0;
    s_load      = 1'b0;
    s_clear     = 1'b0;
    // M refills from the skid entry whenever one is parked, otherwise from the input
    m_load_data = s_valid ? s_pay : in_pay;
    if (Flush) begin
      state_d = EMPTY;
      m_clear = 1'b1;
      s_clear = 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            m_load  = 1'b1;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && retire) begin
            m_load = 1'b1;
          end else if (accept && (SKID != 0)) begin
            s_load  = 1'b1;
            state_d = TWO;
          end else if (retire) begin
            m_clear = 1'b1;
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (retire) begin
            m_load  = 1'b1;
            s_clear = 1'b1;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d  = (state_d != TWO);
    stall_cnt_d = stall_cnt_q;
    if (m_valid && !OutReady && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  pipe_slot #(.W(PAY_W)) u_slot_m (
    .clk     (Clk),
    .rst_n   (Rst_n),
    .load_i  (m_load),
    .clear_i (m_clear),
    .data_i  (m_load_data),
    .valid_o (m_valid),
    .data_o  (m_pay)
  );

  pipe_slot #(.W(PAY_W)) u_slot_s (
    .clk     (Clk),
    .rst_n   (Rst_n),
    .load_i  (s_load),
    .clear_i (s_clear),
    .data_i  (in_pay),
    .valid_o (s_valid),
    .data_o  (s_pay)
  );

  assign {m_ctrl, OutPC, OutRD1, OutRD2, OutImm, OutRd, OutRt} = m_pay;
  assign OutCtrl  = m_valid ? m_ctrl : '0;
  assign OutValid = m_valid;
  assign InReady  = in_ready;
  assign StallCnt = stall_cnt_q;

endmodule
